// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Build option: define LOADER_CHECKSUM_EN to add the trailing XOR checksum byte to the frame.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLenHi  = 3'd1,
        StLenLo  = 3'd2,
        StDataHi = 3'd3,
        StDataLo = 3'd4,
        StDone   = 3'd5,
        StError  = 3'd6
`ifdef LOADER_CHECKSUM_EN
        ,
        StChk    = 3'd7
`endif
    } state_e;

    // Stage that follows the last data word (or LEN_LO when LEN is zero).
`ifdef LOADER_CHECKSUM_EN
    localparam state_e END_STATE = StChk;
`else
    localparam state_e END_STATE = StDone;
`endif

endpackage

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/data frames from a UART byte stream into program-memory writes.
// Build option: LOADER_CHECKSUM_EN adds a CHK byte checked against a running XOR.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = 13,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_mem_we,
    output logic [CODE_WIDTH-1:0] o_mem_addr,
    output logic [15:0]           o_mem_din,
    output logic                  o_cpu_reset,
    output logic                  o_cpu_resume,
    output logic                  o_busy,
    output logic                  o_error
);

    localparam logic [32:0] MAX_LEN = 33'd1 << CODE_WIDTH;

    state_e                r_state;
    state_e                w_next;
    logic [15:0]           r_len;
    logic [7:0]            r_hi;
    logic [CODE_WIDTH:0]   r_cnt;
    logic                  r_we;
    logic [CODE_WIDTH-1:0] r_addr;
    logic [15:0]           r_din;
    logic                  r_resume;
    logic [15:0]           w_len;
    logic                  w_sync;
    logic                  w_last;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            r_xor;
`endif

    assign w_len  = {r_len[15:8], i_rx_data};
    assign w_sync = (i_rx_data == SYNC_BYTE);
    assign w_last = (33'(r_cnt) + 33'd1) == 33'(r_len);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_rx_valid) begin
            unique case (r_state)
                StIdle, StDone, StError: begin
                    if (w_sync) w_next = StLenHi;
                end
                StLenHi:  w_next = StLenLo;
                StLenLo: begin
                    if (33'(w_len) > MAX_LEN) w_next = StError;
                    else if (w_len == 16'd0)  w_next = END_STATE;
                    else                      w_next = StDataHi;
                end
                StDataHi: w_next = StDataLo;
                StDataLo: w_next = w_last ? END_STATE : StDataHi;
`ifdef LOADER_CHECKSUM_EN
                StChk:    w_next = (i_rx_data == r_xor) ? StDone : StError;
`endif
                default:  w_next = StIdle;
            endcase
        end
    end

    always_comb begin
        o_busy      = 1'b1;
        o_cpu_reset = 1'b1;
        o_error     = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                o_busy      = 1'b0;
                o_cpu_reset = 1'b0;
            end
            StError: begin
                o_busy  = 1'b0;
                o_error = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: length, word assembly, write port and the DONE-entry pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_len    <= '0;
            r_hi     <= '0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_resume <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor    <= '0;
`endif
        end else begin
            r_we     <= 1'b0;
            r_resume <= (w_next == StDone) && (r_state != StDone);
            if (i_rx_valid) begin
                case (r_state)
                    StIdle, StDone, StError: begin
                        if (w_sync) begin
                            r_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_xor <= '0;
`endif
                        end
                    end
                    StLenHi:  r_len[15:8] <= i_rx_data;
                    StLenLo:  r_len[7:0]  <= i_rx_data;
                    StDataHi: r_hi        <= i_rx_data;
                    StDataLo: begin
                        r_we   <= 1'b1;
                        r_addr <= r_cnt[CODE_WIDTH-1:0];
                        r_din  <= {r_hi, i_rx_data};
                        r_cnt  <= r_cnt + (CODE_WIDTH + 1)'(1);
                    end
                    default: ;
                endcase
`ifdef LOADER_CHECKSUM_EN
                if (r_state == StLenHi || r_state == StLenLo ||
                    r_state == StDataHi || r_state == StDataLo) begin
                    r_xor <= r_xor ^ i_rx_data;
                end
`endif
            end
        end
    end

    assign o_mem_we     = r_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_din    = r_din;
    assign o_cpu_resume = r_resume;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, hand sequences and random frames.
// Honours LOADER_CHECKSUM_EN the same way the design does.
module tb_prog_loader;

    localparam int unsigned CW   = 13;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef struct packed {
        logic [95:0] bytes;   // right-aligned, first byte most significant
        logic [3:0]  nbytes;
        logic        add_chk;
        logic [2:0]  exp_n;
        logic [63:0] exp_w;   // right-aligned, first word most significant
        logic        exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we;
    logic [CW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          cpu_reset;
    logic          cpu_resume;
    logic          busy;
    logic          error;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [CW+15:0] got_q[$];
    int             resume_cnt = 0;
    int             base_w;
    int             base_r;
    logic [7:0]     frame_q[$];
    logic [15:0]    exp_q[$];
    vec_t           vecs[8];

    prog_loader #(
        .CODE_WIDTH (CW),
        .SYNC_BYTE  (SYNC)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_din    (mem_din),
        .o_cpu_reset  (cpu_reset),
        .o_cpu_resume (cpu_resume),
        .o_busy       (busy),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_din});
        if (cpu_resume === 1'b1) resume_cnt++;
    end

    function automatic vec_t mk(input logic [95:0] b, input int nb, input bit chk,
                                input int en, input logic [63:0] w, input bit err);
        vec_t v;
        v.bytes   = b;
        v.nbytes  = 4'(nb);
        v.add_chk = chk;
        v.exp_n   = 3'(en);
        v.exp_w   = w;
        v.exp_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic play(input bit add_chk, input int gap_max);
        logic [7:0] x;
        bit         seen;
        x    = 8'h00;
        seen = 1'b0;
        foreach (frame_q[i]) begin
            if (seen) x ^= frame_q[i];
            else if (frame_q[i] == SYNC) seen = 1'b1;
        end
`ifdef LOADER_CHECKSUM_EN
        if (add_chk) frame_q.push_back(x);
`endif
        base_w = got_q.size();
        base_r = resume_cnt;
        foreach (frame_q[i]) begin
            send(frame_q[i]);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
        end
    endtask

    task automatic verify(input string name, input bit exp_err);
        int n;
        int bad;
        repeat (3) @(negedge clk);
        n = got_q.size() - base_w;
        check($sformatf("%s writes", name), n, exp_q.size());
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            if (bad < 0 && got_q[base_w+i] !== {CW'(i), exp_q[i]}) bad = i;
        end
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s word[%0d]: got addr/data %h required %h", name, bad,
                     got_q[base_w+bad], {CW'(bad), exp_q[bad]});
        end
        check($sformatf("%s error", name), error, exp_err);
        check($sformatf("%s cpu_reset", name), cpu_reset, exp_err);
        check($sformatf("%s busy", name), busy, 0);
        check($sformatf("%s resume", name), resume_cnt - base_r, exp_err ? 0 : 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        vecs[0] = mk(56'hA5_0002_1234_ABCD, 7, 1, 2, 32'h1234_ABCD, 0);
        vecs[1] = mk(56'h00FF_A5_0001_00A5, 7, 1, 1, 16'h00A5, 0);
        vecs[2] = mk(24'hA5_2001, 3, 0, 0, 0, 1);
        vecs[3] = mk(40'hA5_0001_BEEF, 5, 1, 1, 16'hBEEF, 0);
        vecs[4] = mk(24'hA5_0000, 3, 1, 0, 0, 0);
        vecs[5] = mk(56'hA5_0002_A5A5_A500, 7, 1, 2, 32'hA5A5_A500, 0);
        vecs[6] = mk(24'hA5_FFFF, 3, 0, 0, 0, 1);
        vecs[7] = mk(48'h12_A5_0001_5A5A, 6, 1, 1, 16'h5A5A, 0);

        repeat (2) @(negedge clk);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_din", mem_din, 0);
        check("rst cpu_reset", cpu_reset, 0);
        check("rst cpu_resume", cpu_resume, 0);
        check("rst busy", busy, 0);
        check("rst error", error, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle-level timing of a two-word frame.
        base_w = got_q.size();
        base_r = resume_cnt;
        send(SYNC);
        check("seq1 cpu_reset after sync", cpu_reset, 1);
        check("seq1 busy after sync", busy, 1);
        send(8'h00);
        send(8'h02);
        send(8'h12);
        send(8'h34);
        check("seq1 we after lo", mem_we, 1);
        check("seq1 addr0", mem_addr, 0);
        check("seq1 din0", mem_din, 16'h1234);
        @(posedge clk);
        #1;
        check("seq1 we width", mem_we, 0);
        send(8'hAB);
        send(8'hCD);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00 ^ 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD);
`endif
        check("seq1 resume on done", cpu_resume, 1);
        check("seq1 cpu_reset on done", cpu_reset, 0);
        @(posedge clk);
        #1;
        check("seq1 resume width", cpu_resume, 0);
        exp_q = '{16'h1234, 16'hABCD};
        verify("seq1", 1'b0);

        for (int v = 0; v < 8; v++) begin
            frame_q.delete();
            exp_q.delete();
            for (int i = 0; i < int'(vecs[v].nbytes); i++)
                frame_q.push_back(vecs[v].bytes[8*(int'(vecs[v].nbytes)-1-i) +: 8]);
            for (int i = 0; i < int'(vecs[v].exp_n); i++)
                exp_q.push_back(vecs[v].exp_w[16*(int'(vecs[v].exp_n)-1-i) +: 16]);
            play(vecs[v].add_chk, 1);
            verify($sformatf("vec%0d", v), vecs[v].exp_err);
        end

`ifdef LOADER_CHECKSUM_EN
        // 0x00 ^ 0x01 ^ 0x12 ^ 0x34 = 0x27
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        exp_q   = '{16'h1234};
        play(1'b0, 0);
        verify("chk good", 1'b0);
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        play(1'b0, 0);
        verify("chk bad", 1'b1);
`endif

        // Asynchronous reset in the middle of a frame.
        frame_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        play(1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst mem_we", mem_we, 0);
        check("midrst cpu_reset", cpu_reset, 0);
        check("midrst cpu_resume", cpu_resume, 0);
        check("midrst busy", busy, 0);
        check("midrst error", error, 0);
        check("midrst mem_din", mem_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h77, 8'h88};
        exp_q   = '{16'h7788};
        play(1'b1, 0);
        verify("after rst", 1'b0);

        // LEN = 2**CW fills the whole memory.
        frame_q = '{8'hA5, 8'h20, 8'h00};
        exp_q.delete();
        for (int i = 0; i < (1 << CW); i++) begin
            logic [15:0] w;
            w = 16'(i * 7 + 16'h03C1);
            exp_q.push_back(w);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
        end
        play(1'b1, 0);
        verify("full mem", 1'b0);

        // Random frames against the frame-level model.
        for (int r = 0; r < 40; r++) begin
            int  len;
            bit  err;
            logic [7:0] x;
            frame_q.delete();
            exp_q.delete();
            err = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] j;
                j = 8'($urandom_range(0, 255));
                if (j == SYNC) j = 8'h00;
                frame_q.push_back(j);
            end
            frame_q.push_back(SYNC);
            if ($urandom_range(0, 9) == 0) begin
                len = (1 << CW) + 1 + $urandom_range(0, 5000);
                err = 1'b1;
            end else begin
                len = $urandom_range(0, 6);
            end
            frame_q.push_back(8'(len >> 8));
            frame_q.push_back(8'(len));
            x = 8'(len >> 8) ^ 8'(len);
            if (!err) begin
                for (int i = 0; i < len; i++) begin
                    logic [15:0] w;
                    w = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) w[15:8] = SYNC;
                    exp_q.push_back(w);
                    frame_q.push_back(w[15:8]);
                    frame_q.push_back(w[7:0]);
                    x = x ^ w[15:8] ^ w[7:0];
                end
`ifdef LOADER_CHECKSUM_EN
                if ($urandom_range(0, 3) == 0) begin
                    x   = x ^ 8'($urandom_range(1, 255));
                    err = 1'b1;
                end
                frame_q.push_back(x);
`endif
            end
            play(1'b0, 2);
            verify($sformatf("rand%0d", r), err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
